// File: rtl/period_meter_if.sv
// Result stream of the period meter: measured interval with a valid/ready handshake.
// The meter is the master (producer); the consumer is the slave.
interface period_meter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             period_ready;

  modport master (
    output period,
    output period_valid,
    input  period_ready
  );

  modport slave (
    input  period,
    input  period_valid,
    output period_ready
  );

endinterface

// File: rtl/period_meter.sv
// Period meter: counts clk cycles between consecutive rising edges of an asynchronous
// pulse input and presents each interval through a one-deep valid/ready holding register.
module period_meter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [WIDTH-1:0] timeout,
  output logic             timeout_err,
  output logic             overrun,
  input  logic             overrun_clr,
  period_meter_if.master   res
);

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   delay_q, delay_d;
  logic                   sig_rise;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   res_vld;
  logic                   drop;

  // Synchroniser shift and one-cycle rising-edge detect on its output.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    delay_d  = sync_q[SYNC_STAGES-1];
    sig_rise = sync_q[SYNC_STAGES-1] & ~delay_q;
  end

  // Measurement FSM: arm on the first edge, then report the count at every later edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    res_vld = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) state_d = StArm;
      end
      StArm: begin
        if (sig_rise) begin
          cnt_d   = WIDTH'(1);
          state_d = StMeas;
        end
      end
      StMeas: begin
        // An edge beats a coincident timeout so the interval is still reported.
        if (sig_rise) begin
          res_vld = 1'b1;
          cnt_d   = WIDTH'(1);
        end else if ((timeout != '0) && (cnt_q == timeout)) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = StArm;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Disabling abandons any partial count; a held result is untouched.
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      tmo_d   = 1'b0;
      res_vld = 1'b0;
    end
  end

  // Holding register: accept frees the slot, a new result refills it or is dropped if blocked.
  always_comb begin
    period_d = period_q;
    valid_d  = valid_q;
    drop     = 1'b0;
    if (valid_q && res.period_ready) valid_d = 1'b0;
    if (res_vld) begin
      if (!valid_q || res.period_ready) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    // Set wins over clear in the same cycle.
    overrun_d = (overrun_q & ~overrun_clr) | drop;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      delay_q   <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      delay_q   <= delay_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign res.period       = period_q;
  assign res.period_valid = valid_q;
  assign timeout_err      = tmo_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter (WIDTH=8): directed scenarios plus random pulse trains, all
// compared every cycle against an elapsed-time reference model.
module tb_period_meter;

  localparam int W = 8;
  localparam int SatVal = 255;
  localparam int MIdle = 0, MArm = 1, MMeas = 2;

  logic         clk = 1'b0;
  logic         reset, enable, sig_in, overrun_clr;
  logic [W-1:0] timeout;
  logic         timeout_err, overrun;

  period_meter_if #(.WIDTH(W)) bus ();

  period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sig_in      (sig_in),
    .timeout     (timeout),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .res         (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Next-cycle stimulus, applied by step() just after its checks.
  logic         nxt_rst = 1'b1, nxt_en = 1'b0, nxt_sig = 1'b0, nxt_ready = 1'b1, nxt_clr = 1'b0;
  logic [W-1:0] nxt_timeout = '0;
  bit           rnd_ready = 1'b0, rnd_clr = 1'b0;

  // Reference model: elapsed time since the last detected edge, not a counter.
  int cyc = 0;
  int m_st = MIdle, m_e = 0, m_period = 0;
  bit m_valid = 0, m_tmo = 0, m_ovr = 0;
  bit s1 = 0, s2 = 0, s3 = 0;   // sig_in as driven 1, 2 and 3 cycles ago

  int obs_last = 0;
  int obs_tmo  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Effect of the coming clock edge given the inputs just applied.
  task automatic model();
    bit rise, res_v, drop;
    int elapsed, res_val;
    rise = s2 & ~s3;   // sync + edge latency: a rise driven two cycles ago is seen now
    res_v = 0; drop = 0; res_val = 0;
    if (reset) begin
      m_st = MIdle; m_valid = 0; m_period = 0; m_tmo = 0; m_ovr = 0;
    end else begin
      m_tmo = 0;
      if (!enable) begin
        m_st = MIdle;
      end else begin
        case (m_st)
          MIdle: m_st = MArm;
          MArm: if (rise) begin m_e = cyc; m_st = MMeas; end
          default: begin
            elapsed = cyc - m_e;
            if (elapsed > SatVal) elapsed = SatVal;
            if (rise) begin
              res_v = 1; res_val = elapsed; m_e = cyc;
            end else if (timeout != 0 && elapsed == int'(timeout)) begin
              m_tmo = 1; m_st = MArm;
            end
          end
        endcase
      end
      if (res_v && m_valid && !bus.period_ready) drop = 1;
      if (res_v && !drop) begin
        m_period = res_val; m_valid = 1;
      end else if (m_valid && bus.period_ready) begin
        m_valid = 0;
      end
      m_ovr = (m_ovr && !overrun_clr) || drop;
    end
    s3 = s2; s2 = s1; s1 = sig_in;
  endtask

  task automatic step();
    @(negedge clk);
    check("valid", bus.period_valid, m_valid);
    check("period", bus.period, m_period);
    check("timeout_err", timeout_err, m_tmo);
    check("overrun", overrun, m_ovr);
    if (bus.period_valid) obs_last = bus.period;
    if (timeout_err) obs_tmo++;
    reset   = nxt_rst;
    enable  = nxt_en;
    sig_in  = nxt_sig;
    timeout = nxt_timeout;
    bus.period_ready = rnd_ready ? 1'($urandom_range(0, 1)) : nxt_ready;
    overrun_clr      = rnd_clr ? ($urandom_range(0, 7) == 0) : nxt_clr;
    model();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One period of p cycles, high for the first h of them.
  task automatic pulse(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      nxt_sig = (i < h);
      step();
    end
    nxt_sig = 1'b0;
  endtask

  // Drop enable briefly so the next edge arms rather than completes a stale interval.
  task automatic rearm();
    nxt_en = 1'b0; idle(2);
    nxt_en = 1'b1; idle(2);
  endtask

  int tmo_base, p, h;

  initial begin
    reset = 1'b1; enable = 1'b0; sig_in = 1'b0; overrun_clr = 1'b0; timeout = '0;
    bus.period_ready = 1'b1;
    repeat (2) @(negedge clk);
    idle(3);
    nxt_rst = 1'b0;

    // Steady 10-cycle pulses, always ready.
    nxt_en = 1'b1; nxt_ready = 1'b1; idle(3);
    tmo_base = obs_tmo;
    for (int i = 0; i < 8; i++) pulse(10, int'($urandom_range(1, 9)));
    idle(5);
    check("s1_period", obs_last, 10);
    check("s1_no_tmo", obs_tmo - tmo_base, 0);

    // Consumer stalled: first result held, later ones dropped into overrun.
    rearm();
    nxt_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse(10, 2);
    check("s2_hold", obs_last, 10);
    check("s2_ovr", overrun, 1);
    nxt_clr = 1'b1; step(); nxt_clr = 1'b0; idle(2);
    nxt_ready = 1'b1; idle(3);

    // Timeout after a lone edge, then a 20-cycle interval.
    nxt_timeout = 8'd50; rearm();
    tmo_base = obs_tmo;
    pulse(80, 1);
    check("s3_one_tmo", obs_tmo - tmo_base, 1);
    pulse(20, 1); pulse(20, 1); idle(4);
    check("s3_period", obs_last, 20);

    // Saturation with timeout disabled.
    nxt_timeout = '0; rearm();
    tmo_base = obs_tmo;
    pulse(300, 1); pulse(300, 1); idle(4);
    check("s4_sat", obs_last, SatVal);
    check("s4_no_tmo", obs_tmo - tmo_base, 0);

    // Enable dropped mid-measurement.
    pulse(8, 1);
    nxt_en = 1'b0; idle(5); nxt_en = 1'b1;
    pulse(12, 3); pulse(12, 3); idle(4);
    check("s5_period", obs_last, 12);

    // Reset while a result is held and overrun is set.
    nxt_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse(10, 1);
    check("s6_pre_valid", bus.period_valid, 1);
    check("s6_pre_ovr", overrun, 1);
    nxt_rst = 1'b1; step(); nxt_rst = 1'b0; nxt_ready = 1'b1; step();
    check("s6_rst_valid", bus.period_valid, 0);
    check("s6_rst_ovr", overrun, 0);
    check("s6_rst_period", bus.period, 0);
    idle(3);
    for (int i = 0; i < 4; i++) pulse(7, 3);
    idle(4);
    check("s6_period", obs_last, 7);

    // Random mix: periods, duty, ready, timeout, enable drops and overrun clears.
    rnd_ready = 1'b1; rnd_clr = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0)
        nxt_timeout = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(2, 60));
      if ($urandom_range(0, 14) == 0) begin
        nxt_en = 1'b0; idle(int'($urandom_range(1, 4))); nxt_en = 1'b1;
      end
      p = int'($urandom_range(2, 70));
      h = int'($urandom_range(1, p - 1));
      pulse(p, h);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
